trap_ctrl: RTL and testbench
============================

# trap_ctrl

Memory-mapped trap (interrupt) controller and interval timer that responds on the core's data bus and drives the core's `trap` input. It latches edge-triggered external interrupt requests and a timer event into a pending register, raises `trap` when an enabled source is pending, and completes the trap handshake by capturing the core's trap-save write. Software reads and writes its registers through ordinary loads and stores over the same `strobe`/`mem_rw`/`d_addr`/`d_data` bus.

## Interface
- `BASE`, default 32'h0000_0200: word address of register 0; the block decodes `BASE`..`BASE+7`.
- `TRAP_ADDR`, default 32'h0000_01FF: the address the core writes during a trap acknowledge.
- `NIRQ`, default 8: number of external interrupt lines, 1..31.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `strobe` in 1: bus cycle valid, driven by the core.
- `mem_rw` in 1: 1 = write, 0 = read.
- `d_addr` in 32: word address.
- `d_data` inout 32: write data from the core; read data driven by this block.
- `irq` in NIRQ: asynchronous, rising-edge-sensitive requests.
- `trap` out 1: trap request to the core, registered.

## Operation
Register map (offset from `BASE`):
- 0 STATUS, R/W.
  - bit0 GIE: global enable.
  - bit1 INTRAP: set by a trap acknowledge.
  - Other bits read 0.
- 1 PENDING.
  - Read returns `NIRQ+1` bits. Bit 0 is the timer; bits `1..NIRQ` are `irq[0..NIRQ-1]`.
  - Write-1-to-clear.
- 2 ENABLE, R/W, same bit layout as PENDING.
- 3 EPC, read-only: the PC saved at the last acknowledge. Writes are ignored.
- 4 TCOUNT, R/W, 32-bit.
- 5 TCMP, R/W, 32-bit.
- 6 TCTL, R/W: bit0 RUN.
- 7: reads 0, writes ignored.

Bus rules:
- A read hit is `strobe & !mem_rw & d_addr` in the window. On a read hit, `d_data` is driven combinationally from the current register value in that cycle. In every other case `d_data` is Z.
- A write hit takes effect at the clock edge ending the strobe cycle.
- Accesses outside the window and outside `TRAP_ADDR` are ignored.

Interrupt sources:
- Each `irq` bit passes through a 2-flop synchronizer plus a delay flop.
- A rising edge (synchronized high, delayed low) sets the matching PENDING bit.

Timer:
- When RUN = 1 and TCOUNT == TCMP, TCOUNT becomes 0 and PENDING[0] is set.
- When RUN = 1 and there is no match, TCOUNT increments, wrapping 32'hFFFF_FFFF to 0.
- When RUN = 0, TCOUNT holds.

Trap request:
- `trap` next value = GIE & !INTRAP & |(PENDING & ENABLE).

Acknowledge:
- An acknowledge is `strobe & mem_rw & d_addr == TRAP_ADDR`. At that edge: EPC <= `d_data`, INTRAP <= 1, GIE <= 0, `trap` <= 0.
- The acknowledge overrides the trap-request equation.
- An acknowledge is honored whether or not `trap` is high.
- Return from trap: software writes STATUS, for example 1 (GIE = 1, INTRAP = 0).

Simultaneous events:
- A source edge and a W1C of the same PENDING bit in one cycle: the bit ends up set.
- A TCOUNT write and a timer tick in one cycle: the written value wins. A match on the pre-write value still sets PENDING[0].
- A STATUS write and an acknowledge in one cycle: the acknowledge wins.
- A timer match while its PENDING bit is already set: the bit stays set. Events are not counted.

Reset (synchronous, honored at any point, including mid-trap):
- STATUS, PENDING, ENABLE, EPC, TCOUNT, TCTL and the synchronizer flops go to 0.
- TCMP goes to 32'hFFFF_FFFF.
- `trap` goes to 0; `d_data` is Z.
- An `irq` held high through reset produces no edge after reset.

## Timing
- Read latency is 0 cycles: data is valid in the strobe cycle, and the core samples it at the end of that cycle.
- `irq` high before edge n: synchronizer stage 1 at n, stage 2 at n+1, PENDING set at n+2, `trap` high after n+3.
- Timer match at edge m: PENDING[0] set at m; `trap` high after m+1 if enabled.
- Acknowledge strobe in cycle c: `trap` is low from the cycle after c onward (the core's wait cycle). EPC is readable from cycle c+1.
- Writes to ENABLE or STATUS affect `trap` one edge after the write edge.

## Test plan
- Reset state: after reset, read offsets 0-7 -> 0, 0, 0, 0, 0, FFFFFFFF, 0, 0. `trap` = 0. `d_data` = Z when not read-hit.
- External IRQ: ENABLE = 0x4, STATUS = 1, pulse `irq[1]` for 3 cycles -> PENDING = 0x4 and `trap` = 1 exactly 4 edges after the rise. Acknowledge write of 0x123 -> `trap` = 0 next cycle, EPC = 0x123, STATUS = 2.
- Timer: TCMP = 5, TCTL = 1, ENABLE = 1, STATUS = 1 -> PENDING[0] set 6 edges after RUN is set and TCOUNT returns to 0. Write PENDING = 1 -> cleared.
- Masking: pending set with ENABLE = 0 or GIE = 0 -> `trap` stays 0. Enabling both -> `trap` = 1 one edge later.
- Collision: W1C of PENDING[2] on the same edge as a new `irq[1]` edge -> PENDING[2] = 1. Write TCOUNT = 7 on a match edge -> TCOUNT = 7 and PENDING[0] = 1.
- Reset mid-trap: assert `reset_n` = 0 while `trap` = 1 and INTRAP = 1 -> next edge `trap` = 0 and all registers at reset values. An `irq` held high produces no PENDING bit.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Core-side bus controls, external interrupt lines and the trap request of trap_ctrl.
// The bidirectional data bus stays a plain port on the controller.
interface trap_ctrl_if #(
  parameter int NIRQ = 8
);
  logic            strobe;
  logic            mem_rw;
  logic [31:0]     d_addr;
  logic [NIRQ-1:0] irq;
  logic            trap;

  modport master (output strobe, output mem_rw, output d_addr, output irq, input trap);
  modport slave  (input strobe, input mem_rw, input d_addr, input irq, output trap);
endinterface

// File: rtl/trap_ctrl.sv
// Memory-mapped trap controller with edge-latched interrupts and an interval timer;
// answers loads/stores in an 8-word window and captures the core's trap-save write.
module trap_ctrl #(
  parameter logic [31:0] BASE      = 32'h0000_0200,
  parameter logic [31:0] TRAP_ADDR = 32'h0000_01FF,
  parameter int          NIRQ      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  trap_ctrl_if.slave bus,
  inout  wire [31:0] d_data
);
  localparam int PW = NIRQ + 1;

  logic [31:0]     off;
  logic            in_win, rd_hit, wr_hit, ack;

  logic            gie_q, gie_d, intrap_q, intrap_d;
  logic            run_q, run_d, trap_q, trap_d;
  logic [PW-1:0]   pend_q, pend_d, en_q, en_d;
  logic [31:0]     epc_q, epc_d, tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic [NIRQ-1:0] sync1_q, sync2_q, dly_q, blk_q, blk_d, rise;
  logic [1:0]      settle_q, settle_d;
  logic            tmatch;
  logic [31:0]     rdata;

  function automatic logic [31:0] count_next(input logic run, input logic match,
                                             input logic [31:0] cnt);
    if (!run)       return cnt;
    else if (match) return 32'd0;
    else            return cnt + 32'd1;
  endfunction

  // Unsigned offset makes the window test immune to wrap around BASE.
  assign off    = bus.d_addr - BASE;
  assign in_win = (off[31:3] == 29'd0);
  assign rd_hit = bus.strobe & ~bus.mem_rw & in_win;
  assign wr_hit = bus.strobe &  bus.mem_rw & in_win;
  assign ack    = bus.strobe &  bus.mem_rw & (bus.d_addr == TRAP_ADDR);

  assign bus.trap = trap_q;
  assign d_data   = rd_hit ? rdata : 32'hzzzz_zzzz;

  always_comb begin
    rdata = 32'd0;
    case (off[2:0])
      3'd0:    rdata[1:0]    = {intrap_q, gie_q};
      3'd1:    rdata[PW-1:0] = pend_q;
      3'd2:    rdata[PW-1:0] = en_q;
      3'd3:    rdata         = epc_q;
      3'd4:    rdata         = tcount_q;
      3'd5:    rdata         = tcmp_q;
      3'd6:    rdata[0]      = run_q;
      default: rdata         = 32'd0;
    endcase
  end

  always_comb begin
    // A line that was high when reset released stays blocked until it is seen low
    // once the synchronizer has refilled, so a held request cannot fake an edge.
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    blk_d    = (settle_q == 2'd2) ? (blk_q & sync2_q) : blk_q;
    rise     = sync2_q & ~dly_q & ~blk_q;

    tmatch   = run_q & (tcount_q == tcmp_q);
    tcount_d = count_next(run_q, tmatch, tcount_q);

    gie_d    = gie_q;
    intrap_d = intrap_q;
    pend_d   = pend_q;
    en_d     = en_q;
    epc_d    = epc_q;
    tcmp_d   = tcmp_q;
    run_d    = run_q;

    if (wr_hit) begin
      case (off[2:0])
        3'd0:    {intrap_d, gie_d} = d_data[1:0];
        3'd1:    pend_d   = pend_q & ~d_data[PW-1:0];
        3'd2:    en_d     = d_data[PW-1:0];
        3'd4:    tcount_d = d_data;
        3'd5:    tcmp_d   = d_data;
        3'd6:    run_d    = d_data[0];
        default: ;
      endcase
    end

    // New events are ORed in after the W1C so a coincident edge is never lost.
    pend_d = pend_d | {rise, tmatch};
    trap_d = gie_q & ~intrap_q & (|(pend_q & en_q));

    if (ack) begin
      epc_d    = d_data;
      intrap_d = 1'b1;
      gie_d    = 1'b0;
      trap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gie_q    <= 1'b0;
      intrap_q <= 1'b0;
      run_q    <= 1'b0;
      trap_q   <= 1'b0;
      pend_q   <= '0;
      en_q     <= '0;
      epc_q    <= 32'd0;
      tcount_q <= 32'd0;
      tcmp_q   <= 32'hFFFF_FFFF;
      sync1_q  <= '0;
      sync2_q  <= '0;
      dly_q    <= '0;
      blk_q    <= '1;
      settle_q <= 2'd0;
    end else begin
      gie_q    <= gie_d;
      intrap_q <= intrap_d;
      run_q    <= run_d;
      trap_q   <= trap_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      epc_q    <= epc_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      sync1_q  <= bus.irq;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      blk_q    <= blk_d;
      settle_q <= settle_d;
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: literal expectations plus a per-cycle register-level
// model checked against trap and every read.
`timescale 1ns/1ps
module tb_trap_ctrl;
  localparam int          NIRQ      = 8;
  localparam logic [31:0] BASE      = 32'h0000_0200;
  localparam logic [31:0] TRAP_ADDR = 32'h0000_01FF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  wire  [31:0] d_data;
  logic [31:0] wdata = 32'd0;
  logic        drv = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        seen_rst = 1'b0;

  assign d_data = drv ? wdata : 32'hzzzz_zzzz;

  trap_ctrl_if #(.NIRQ(NIRQ)) bus ();

  trap_ctrl #(.BASE(BASE), .TRAP_ADDR(TRAP_ADDR), .NIRQ(NIRQ)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .d_data(d_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: register file plus the last three irq samples taken at clock edges.
  typedef struct packed {
    logic            gie, intrap, run, trap;
    logic [NIRQ:0]   pend, en;
    logic [31:0]     epc, tcount, tcmp;
    logic [NIRQ-1:0] h0, h1, h2;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic rst_n, input logic stb,
                                         input logic rw, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [NIRQ-1:0] irq);
    mstate_t         n;
    logic [31:0]     o;
    logic            wr, ack, match;
    logic [NIRQ-1:0] rise;
    n = s;
    if (!rst_n) begin
      n = '0;
      n.tcmp = 32'hFFFF_FFFF;
      n.h0 = '1; n.h1 = '1; n.h2 = '1;
      return n;
    end
    o     = addr - BASE;
    wr    = stb && rw && (o < 32'd8);
    ack   = stb && rw && (addr == TRAP_ADDR);
    match = s.run && (s.tcount == s.tcmp);
    rise  = s.h1 & ~s.h2;
    n.h0 = irq; n.h1 = s.h0; n.h2 = s.h1;
    n.trap = s.gie && !s.intrap && ((s.pend & s.en) != '0);
    if (s.run) n.tcount = match ? 32'd0 : s.tcount + 32'd1;
    if (wr) begin
      case (o)
        32'd0: begin n.gie = wd[0]; n.intrap = wd[1]; end
        32'd1: n.pend = s.pend & ~wd[NIRQ:0];
        32'd2: n.en = wd[NIRQ:0];
        32'd4: n.tcount = wd;
        32'd5: n.tcmp = wd;
        32'd6: n.run = wd[0];
        default: ;
      endcase
    end
    n.pend = n.pend | {rise, match};
    if (ack) begin
      n.epc = wd; n.intrap = 1'b1; n.gie = 1'b0; n.trap = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] o);
    case (o)
      32'd0:   return {30'd0, s.intrap, s.gie};
      32'd1:   return 32'(s.pend);
      32'd2:   return 32'(s.en);
      32'd3:   return s.epc;
      32'd4:   return s.tcount;
      32'd5:   return s.tcmp;
      32'd6:   return {31'd0, s.run};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    m <= model_step(m, reset_n, bus.strobe, bus.mem_rw, bus.d_addr, wdata, bus.irq);
    if (!reset_n) seen_rst <= 1'b1;
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      check("model trap", {31'd0, bus.trap}, {31'd0, m.trap});
      if (bus.strobe && !bus.mem_rw && ((bus.d_addr - BASE) < 32'd8))
        check("model read", d_data, model_read(m, bus.d_addr - BASE));
    end
  end

  task automatic bus_idle();
    @(posedge clk); #1;
    bus.strobe = 1'b0; bus.mem_rw = 1'b0; drv = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.strobe = 1'b1; bus.mem_rw = 1'b1; bus.d_addr = a; wdata = d; drv = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.strobe = 1'b1; bus.mem_rw = 1'b0; bus.d_addr = a; drv = 1'b0;
    #2 check(nm, d_data, exp);
  endtask

  task automatic chk_trap(input string nm, input logic e);
    check(nm, {31'd0, bus.trap}, {31'd0, e});
  endtask

  initial begin
    bus.strobe = 1'b0; bus.mem_rw = 1'b0; bus.d_addr = 32'd0; bus.irq = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_trap("reset trap", 1'b0);
    for (int i = 0; i < 8; i++)
      rd($sformatf("reset reg%0d", i), BASE + 32'(i), (i == 5) ? 32'hFFFF_FFFF : 32'd0);

    // External request on irq[1] -> PENDING bit 2
    wr(BASE + 2, 32'h4);
    wr(BASE + 0, 32'h1);
    @(posedge clk); #1;
    bus.strobe = 1'b0; drv = 1'b0; bus.irq[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 2) bus.irq[1] = 1'b0;
      chk_trap($sformatf("irq trap edge%0d", k + 1), k == 3);
    end
    rd("irq pending", BASE + 1, 32'h4);
    wr(TRAP_ADDR, 32'h123);
    bus_idle();
    chk_trap("ack trap low", 1'b0);
    rd("ack epc", BASE + 3, 32'h123);
    rd("ack status", BASE + 0, 32'h2);
    wr(BASE + 1, 32'h1FF);
    wr(BASE + 0, 32'h0);
    wr(BASE + 2, 32'h0);

    // Interval timer
    wr(BASE + 5, 32'd5);
    wr(BASE + 2, 32'h1);
    wr(BASE + 0, 32'h1);
    wr(BASE + 6, 32'h1);
    for (int k = 0; k < 6; k++) rd($sformatf("tcount %0d", k), BASE + 4, 32'(k));
    rd("tcount wrap", BASE + 4, 32'd0);
    rd("timer pending", BASE + 1, 32'h1);
    chk_trap("timer trap", 1'b1);
    wr(BASE + 6, 32'h0);
    wr(BASE + 1, 32'h1);
    rd("timer w1c", BASE + 1, 32'h0);
    wr(BASE + 0, 32'h0);
    wr(BASE + 2, 32'h0);

    // Masking by ENABLE and by GIE
    @(posedge clk); #1;
    bus.strobe = 1'b0; drv = 1'b0; bus.irq[0] = 1'b1;
    repeat (5) begin bus_idle(); chk_trap("mask idle trap", 1'b0); end
    bus.irq[0] = 1'b0;
    rd("mask pending", BASE + 1, 32'h2);
    wr(BASE + 0, 32'h1);
    bus_idle(); bus_idle();
    chk_trap("enable off trap", 1'b0);
    wr(BASE + 0, 32'h0);
    wr(BASE + 2, 32'h2);
    bus_idle(); bus_idle();
    chk_trap("gie off trap", 1'b0);
    wr(BASE + 0, 32'h1);
    bus_idle();
    chk_trap("unmask edge trap", 1'b0);
    bus_idle();
    chk_trap("unmask next trap", 1'b1);
    wr(TRAP_ADDR, 32'h55);
    wr(BASE + 1, 32'h1FF);
    wr(BASE + 0, 32'h0);
    wr(BASE + 2, 32'h0);

    // Edge and W1C on the same PENDING bit
    @(posedge clk); #1;
    bus.strobe = 1'b0; drv = 1'b0; bus.irq[1] = 1'b1;
    bus_idle();
    wr(BASE + 1, 32'h4);
    bus_idle();
    bus.irq[1] = 1'b0;
    rd("collide pend bit2", BASE + 1, 32'h4);

    // TCOUNT write on a match edge
    wr(BASE + 4, 32'd0);
    wr(BASE + 5, 32'd3);
    wr(BASE + 6, 32'h1);
    bus_idle(); bus_idle(); bus_idle();
    wr(BASE + 4, 32'd7);
    rd("collide tcount", BASE + 4, 32'd7);
    rd("collide pend", BASE + 1, 32'h5);
    wr(BASE + 6, 32'h0);

    // Reset during the acknowledge of a live trap, with irq[3] held high
    wr(BASE + 2, 32'h4);
    wr(BASE + 0, 32'h1);
    bus_idle();
    bus.irq[3] = 1'b1;
    bus_idle();
    chk_trap("pre-reset trap", 1'b1);
    wr(TRAP_ADDR, 32'h77);
    reset_n = 1'b0;
    bus_idle();
    chk_trap("reset mid-trap", 1'b0);
    bus_idle();
    reset_n = 1'b1;
    repeat (8) bus_idle();
    for (int i = 0; i < 8; i++)
      rd($sformatf("post-reset reg%0d", i), BASE + 32'(i), (i == 5) ? 32'hFFFF_FFFF : 32'd0);
    bus.irq[3] = 1'b0;
    repeat (4) bus_idle();
    bus.irq[3] = 1'b1;
    repeat (4) bus_idle();
    rd("fresh edge pend", BASE + 1, 32'h10);
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
